// File: rtl/od_rx_pkg.sv
// Shared constants for the open-drain line receiver and the driver models
// that pull those lines low.
package od_rx_pkg;

    localparam int OD_RX_FILTER_DEF     = 3;
    localparam int OD_RX_WIDTH_BITS_DEF = 12;

    // Level an open-drain driver pulls the net to; released nets float high.
    localparam logic OD_ASSERTED_LEVEL = 1'b0;

    // Bits needed for a filter counter that counts 0 .. filter-1.
    function automatic int od_rx_cnt_bits(input int filter);
        return (filter > 1) ? $clog2(filter) : 1;
    endfunction

endpackage

// File: rtl/od_rx_channel.sv
// One open-drain line: level resolve, 2-flop sync, glitch filter, edge strobes,
// low-pulse width measurement and a valid/ack hand-off of each width.
module od_rx_channel
    import od_rx_pkg::*;
#(
    parameter int FILTER     = OD_RX_FILTER_DEF,
    parameter int WIDTH_BITS = OD_RX_WIDTH_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line,
    output logic                  asserted,
    output logic                  assert_pulse,
    output logic                  release_pulse,
    output logic [WIDTH_BITS-1:0] width,
    output logic                  width_valid,
    input  logic                  width_ack,
    output logic                  overrun
);

    localparam int                  CW       = od_rx_cnt_bits(FILTER);
    localparam logic [CW-1:0]       CNT_LAST = CW'(FILTER - 1);
    localparam logic [WIDTH_BITS-1:0] WC_MAX = '1;
    localparam logic [WIDTH_BITS-1:0] WC_ONE = WIDTH_BITS'(1);

    logic                  raw;
    logic                  s1;
    logic                  s2;
    logic [CW-1:0]         cnt;
    logic [WIDTH_BITS-1:0] wc;
    logic                  toggle;
    logic                  rise;
    logic                  fall;
    logic                  ack_hit;

    // Only a hard 0 counts as asserted; z/x/1 mean the pull-up has the net.
    assign raw = (line === OD_ASSERTED_LEVEL);

    always_comb begin
        toggle  = 1'b0;
        rise    = 1'b0;
        fall    = 1'b0;
        ack_hit = 1'b0;
        if ((s2 != asserted) && (cnt == CNT_LAST)) begin
            toggle = 1'b1;
        end
        rise    = toggle & ~asserted;
        fall    = toggle & asserted;
        ack_hit = width_ack & width_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            asserted <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == asserted) begin
                cnt <= '0;
            end else if (toggle) begin
                cnt      <= '0;
                asserted <= ~asserted;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            wc            <= '0;
        end else begin
            assert_pulse  <= rise;
            release_pulse <= fall;
            // wc counts the cycles asserted is 1, starting at 1 on the rise edge.
            if (rise) begin
                wc <= WC_ONE;
            end else if (asserted && (wc != WC_MAX)) begin
                wc <= wc + 1'b1;
            end
        end
    end

    // Handshake: width_valid means width holds data not yet consumed; the
    // consumer raises width_ack for one or more cycles and the first edge with
    // both high consumes it. A new width arriving on that same edge wins and
    // stays valid; a new width arriving while still valid sets overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            width       <= '0;
            width_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (fall) begin
            width       <= wc;
            width_valid <= 1'b1;
            if (width_valid && !width_ack) begin
                overrun <= 1'b1;
            end
        end else if (ack_hit) begin
            width_valid <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule

// File: rtl/od_line_receiver.sv
// Capture end of a bank of pulled-up open-drain lines: one od_rx_channel per
// net, with the per-channel widths packed side by side on one bus.
module od_line_receiver
    import od_rx_pkg::*;
#(
    parameter int CHANNELS   = 6,
    parameter int FILTER     = OD_RX_FILTER_DEF,
    parameter int WIDTH_BITS = OD_RX_WIDTH_BITS_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            line,
    output logic [CHANNELS-1:0]            asserted,
    output logic [CHANNELS-1:0]            assert_pulse,
    output logic [CHANNELS-1:0]            release_pulse,
    output logic [CHANNELS*WIDTH_BITS-1:0] width,
    output logic [CHANNELS-1:0]            width_valid,
    input  logic [CHANNELS-1:0]            width_ack,
    output logic [CHANNELS-1:0]            overrun
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        od_rx_channel #(
            .FILTER     (FILTER),
            .WIDTH_BITS (WIDTH_BITS)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .line          (line[i]),
            .asserted      (asserted[i]),
            .assert_pulse  (assert_pulse[i]),
            .release_pulse (release_pulse[i]),
            .width         (width[i*WIDTH_BITS +: WIDTH_BITS]),
            .width_valid   (width_valid[i]),
            .width_ack     (width_ack[i]),
            .overrun       (overrun[i])
        );
    end

endmodule

// File: tb/tb_od_line_receiver.sv
// Bench for od_line_receiver: directed scenarios plus random pulse trains,
// with strobe timing and widths checked from an expected-event scoreboard.
module tb_od_line_receiver;

    localparam int CH  = 6;
    localparam int WB  = 8;
    localparam int FLT = 3;
    localparam int LAT = 2 + FLT;
    localparam int MAXW = (1 << WB) - 1;

    logic             clk;
    logic             rst;
    logic [CH-1:0]    line;
    logic [CH-1:0]    asserted;
    logic [CH-1:0]    assert_pulse;
    logic [CH-1:0]    release_pulse;
    logic [CH*WB-1:0] width;
    logic [CH-1:0]    width_valid;
    logic [CH-1:0]    width_ack;
    logic [CH-1:0]    overrun;

    int cyc = 0;
    int total_cnt = 0;
    int pass_cnt = 0;

    // Scoreboard: expected strobe cycles and widths, per channel.
    int          exp_a_q[CH][$];
    int          exp_r_q[CH][$];
    logic [WB-1:0] exp_w_q[CH][$];
    int          n_strobe[CH];
    logic [CH-1:0] hi_seen = '0;

    od_line_receiver #(
        .CHANNELS   (CH),
        .FILTER     (FLT),
        .WIDTH_BITS (WB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .line          (line),
        .asserted      (asserted),
        .assert_pulse  (assert_pulse),
        .release_pulse (release_pulse),
        .width         (width),
        .width_valid   (width_valid),
        .width_ack     (width_ack),
        .overrun       (overrun)
    );

    // Clock and cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: cycle %0d reached, required finish before time limit", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int ch, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s ch%0d: got %0d, expected %0d (cycle %0d)",
                     name, ch, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [WB-1:0] sat_w(input int len);
        return (len > MAXW) ? WB'(MAXW) : WB'(len);
    endfunction

    // Low pulse of len cycles; assert/release strobes land LAT edges after
    // each line edge, and the reported width is the low time (saturated).
    task automatic pulse(input int ch, input int len);
        line[ch] = 1'b0;
        exp_a_q[ch].push_back(cyc + LAT);
        step(len);
        line[ch] = 1'b1;
        exp_r_q[ch].push_back(cyc + LAT);
        exp_w_q[ch].push_back(sat_w(len));
    endtask

    task automatic ack_once(input int ch);
        width_ack[ch] = 1'b1;
        step(1);
        width_ack[ch] = 1'b0;
    endtask

    task automatic rand_chan(input int ch);
        for (int k = 0; k < 6; k++) begin
            int t;
            pulse(ch, int'($urandom_range(3, 40)));
            t = 0;
            while (!width_valid[ch] && t < 30) begin
                step(1);
                t++;
            end
            chk("rand_valid_wait", ch, 32'(width_valid[ch]), 32'd1);
            ack_once(ch);
            step(int'($urandom_range(3, 12)));
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge clk) begin
        hi_seen <= hi_seen | asserted;
        for (int i = 0; i < CH; i++) begin
            if (assert_pulse[i]) begin
                n_strobe[i]++;
                if (exp_a_q[i].size() == 0) begin
                    chk("assert_pulse_unexpected", i, 32'(assert_pulse[i]), 32'd0);
                end else begin
                    chk("assert_cycle", i, 32'(cyc), 32'(exp_a_q[i].pop_front()));
                end
            end
            if (release_pulse[i]) begin
                n_strobe[i]++;
                if (exp_r_q[i].size() == 0) begin
                    chk("release_pulse_unexpected", i, 32'(release_pulse[i]), 32'd0);
                end else begin
                    chk("release_cycle", i, 32'(cyc), 32'(exp_r_q[i].pop_front()));
                    chk("width", i, 32'(width[i*WB +: WB]), 32'(exp_w_q[i].pop_front()));
                    chk("width_valid_on_release", i, 32'(width_valid[i]), 32'd1);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_asserted"}, 0, 32'(asserted), 32'd0);
        chk({tag, "_assert_pulse"}, 0, 32'(assert_pulse), 32'd0);
        chk({tag, "_release_pulse"}, 0, 32'(release_pulse), 32'd0);
        chk({tag, "_width"}, 0, 32'(width[31:0]), 32'd0);
        chk({tag, "_width_hi"}, 0, 32'(width[CH*WB-1:32]), 32'd0);
        chk({tag, "_width_valid"}, 0, 32'(width_valid), 32'd0);
        chk({tag, "_overrun"}, 0, 32'(overrun), 32'd0);
    endtask

    initial begin
        int tot;
        rst       = 1'b0;
        line      = '1;
        width_ack = '0;
        for (int i = 0; i < CH; i++) n_strobe[i] = 0;
        @(posedge clk);
        #1;
        step(3);
        chk_all_zero("reset");
        rst = 1'b1;

        // All lines released: nothing happens.
        step(20);
        chk("idle_asserted", 0, 32'(asserted), 32'd0);
        chk("idle_valid", 0, 32'(width_valid), 32'd0);
        tot = 0;
        for (int i = 0; i < CH; i++) tot += n_strobe[i];
        chk("idle_strobes", 0, 32'(tot), 32'd0);

        // ch0: 10-cycle pulse, then consume it.
        pulse(0, 10);
        step(LAT);
        chk("ch0_valid", 0, 32'(width_valid[0]), 32'd1);
        ack_once(0);
        chk("ch0_valid_after_ack", 0, 32'(width_valid[0]), 32'd0);
        chk("ch0_width_held", 0, 32'(width[7:0]), 32'd10);

        // ch1: glitches shorter than the filter.
        line[1] = 1'b0; step(1); line[1] = 1'b1;
        step(5);
        line[1] = 1'b0; step(2); line[1] = 1'b1;
        step(10);
        chk("ch1_glitch_asserted", 1, 32'(hi_seen[1]), 32'd0);
        chk("ch1_glitch_strobes", 1, 32'(n_strobe[1]), 32'd0);

        // ch2: saturation, then overwrite without ack.
        pulse(2, 300);
        step(8);
        chk("ch2_sat_width", 2, 32'(width[2*WB +: WB]), 32'(MAXW));
        pulse(2, 4);
        step(LAT);
        chk("ch2_overrun_set", 2, 32'(overrun[2]), 32'd1);
        chk("ch2_valid_kept", 2, 32'(width_valid[2]), 32'd1);
        ack_once(2);
        chk("ch2_valid_cleared", 2, 32'(width_valid[2]), 32'd0);
        chk("ch2_overrun_cleared", 2, 32'(overrun[2]), 32'd0);

        // ch3: release lands on the same edge as an ack of the previous width.
        pulse(3, 6);
        step(8);
        line[3] = 1'b0;
        exp_a_q[3].push_back(cyc + LAT);
        step(8);
        line[3] = 1'b1;
        exp_r_q[3].push_back(cyc + LAT);
        exp_w_q[3].push_back(sat_w(8));
        step(LAT - 1);
        ack_once(3);
        chk("ch3_coincident_width", 3, 32'(width[3*WB +: WB]), 32'd8);
        chk("ch3_coincident_valid", 3, 32'(width_valid[3]), 32'd1);
        chk("ch3_coincident_overrun", 3, 32'(overrun[3]), 32'd0);
        ack_once(3);
        chk("ch3_valid_cleared", 3, 32'(width_valid[3]), 32'd0);
        ack_once(3);
        chk("ch3_idle_ack_valid", 3, 32'(width_valid[3]), 32'd0);
        chk("ch3_idle_ack_width", 3, 32'(width[3*WB +: WB]), 32'd8);

        // Random independent pulse trains on every channel.
        fork
            rand_chan(0);
            rand_chan(1);
            rand_chan(2);
            rand_chan(3);
            rand_chan(4);
            rand_chan(5);
        join
        step(10);
        chk("rand_overrun", 0, 32'(overrun), 32'd0);
        chk("rand_valid", 0, 32'(width_valid), 32'd0);

        // ch4: reset in the middle of a pulse.
        line[4] = 1'b0;
        exp_a_q[4].push_back(cyc + LAT);
        step(10);
        rst = 1'b0;
        step(1);
        chk_all_zero("midreset");
        rst = 1'b1;
        exp_a_q[4].push_back(cyc + LAT);
        step(10);
        line[4] = 1'b1;
        exp_r_q[4].push_back(cyc + LAT);
        exp_w_q[4].push_back(sat_w(10));
        step(LAT + 5);
        chk("ch4_after_reset_valid", 4, 32'(width_valid[4]), 32'd1);

        step(5);
        for (int i = 0; i < CH; i++) begin
            chk("pending_assert", i, 32'(exp_a_q[i].size()), 32'd0);
            chk("pending_release", i, 32'(exp_r_q[i].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
